lsu_dccm_dma_req: RTL and testbench
===================================

LSU_DCCM_DMA_REQ -- requirements
Module: lsu_dccm_dma_req

Interface
REQ-001 SHALL have parameter DCCM_BITS, default 16, meaning DCCM byte-address width.
REQ-002 SHALL have parameter DCCM_FDATA_WIDTH, default 39, meaning DCCM word width (data plus ECC, passed through untouched).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive blocked cycles before a priority request is raised.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, reset; reset is asynchronous and active-high.
REQ-006 SHALL have ports dma_req_valid (input, 1), dma_req_ready (output, 1), dma_req_write (input, 1), dma_req_addr (input, DCCM_BITS) and dma_req_wdata (input, DCCM_FDATA_WIDTH), forming the DMA request channel.
REQ-007 SHALL have ports dma_rsp_valid (output, 1), dma_rsp_ready (input, 1), dma_rsp_write (output, 1), dma_rsp_err (output, 1) and dma_rsp_rdata (output, DCCM_FDATA_WIDTH), forming the response channel.
REQ-008 SHALL have ports core_dccm_busy (input, 1), meaning the core pipe owns the DCCM this cycle, and lsu_freeze_dc3 (input, 1), meaning the pipe is frozen.
REQ-009 SHALL have outputs dccm_wren (1), dccm_rden (1), dccm_wr_addr, dccm_rd_addr_lo and dccm_rd_addr_hi (each DCCM_BITS), and dccm_wr_data (DCCM_FDATA_WIDTH), which drive the DCCM port.
REQ-010 SHALL have input dccm_rd_data_lo (DCCM_FDATA_WIDTH), the DCCM read data, valid one cycle after rden.
REQ-011 SHALL have output dma_prio_req (1), which asks the core to yield the DCCM.

Function
REQ-012 SHALL implement an FSM with states IDLE, ISSUE, RDATA and RSP.
REQ-013 SHALL drive dma_req_ready=1 only in IDLE.
REQ-014 On an IDLE handshake, SHALL register write, addr and wdata; addr[1:0]!=0 goes to RSP with err=1, otherwise to ISSUE.
REQ-015 A misaligned request SHALL never assert dccm_wren or dccm_rden.
REQ-016 In ISSUE, the access SHALL fire the same cycle when ~core_dccm_busy & ~lsu_freeze_dc3; otherwise the FSM SHALL stay in ISSUE with all DCCM enables at 0.
REQ-017 A fired write SHALL assert dccm_wren for exactly 1 cycle with dccm_wr_addr=addr and dccm_wr_data=wdata, then go to RSP.
REQ-018 A fired read SHALL assert dccm_rden for exactly 1 cycle with dccm_rd_addr_lo=dccm_rd_addr_hi=addr, then go to RDATA.
REQ-019 In RDATA, SHALL capture dccm_rd_data_lo into dma_rsp_rdata and go to RSP when ~lsu_freeze_dc3; while frozen, SHALL hold in RDATA (the memory holds Q).
REQ-020 In RSP, SHALL assert dma_rsp_valid with stable write/err/rdata; on dma_rsp_ready, SHALL go to IDLE with no new request accepted that same cycle.
REQ-021 For writes and errors, dma_rsp_rdata SHALL be 0.
REQ-022 Best-case latency from request handshake to dma_rsp_valid SHALL be 2 cycles for writes and 3 cycles for reads.
REQ-023 The starve counter SHALL increment each ISSUE cycle in which the access does not fire, saturating at STARVE_LIMIT, and clear when the access fires or the FSM leaves ISSUE.
REQ-024 dma_prio_req SHALL equal (state==ISSUE) & (counter==STARVE_LIMIT), registered-state based with no combinational path from core_dccm_busy.
REQ-025 Address outputs SHALL be 0 whenever the corresponding enable is 0.
REQ-026 At most one DCCM enable SHALL be active in any cycle.

Reset
REQ-027 On rst assertion, SHALL asynchronously enter IDLE with all registers and the counter at 0 and all outputs 0 except dma_req_ready=1, including when reset arrives mid-RDATA or mid-RSP.
REQ-028 After rst deasserts, the first request SHALL be accepted in the first cycle with dma_req_valid=1.

Verification
REQ-029 Write addr=0x0010, wdata=0x12345678, bench idle -> 1-cycle dccm_wren with the same addr and data; rsp write=1, err=0, 2 cycles after the handshake.
REQ-030 Read addr=0x0010 after REQ-029, memory returns 0x12345678 -> 1-cycle rden with lo=hi=0x0010; rdata=0x12345678 at cycle 3.
REQ-031 Read with core_dccm_busy=1 for 6 cycles -> dma_prio_req rises in the 5th blocked cycle and holds until the access fires; counter then 0.
REQ-032 Read with lsu_freeze_dc3=1 during RDATA for 3 cycles -> rsp delayed 3 cycles; rdata correct.
REQ-033 Request addr=0x0013 -> no DCCM enable; rsp err=1, rdata=0 after 1 cycle.
REQ-034 rst pulse in RDATA, then dma_rsp_ready held 0 -> IDLE, ready=1, no rsp_valid, no DCCM enable.

Source files
------------

// File: rtl/lsu_dccm_dma_req.sv
// Purpose: arbitrates single DMA word accesses onto the shared DCCM port, yielding to the core pipe.
// Latency: 2 cycles from request handshake to response for writes, 3 for reads, 1 for misaligned errors.
// Backpressure: one request in flight; stalls on core_dccm_busy/lsu_freeze_dc3 and dma_rsp_ready.
module lsu_dccm_dma_req #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dma_req_valid,
    output logic                        dma_req_ready,
    input  logic                        dma_req_write,
    input  logic [DCCM_BITS-1:0]        dma_req_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] dma_req_wdata,
    output logic                        dma_rsp_valid,
    input  logic                        dma_rsp_ready,
    output logic                        dma_rsp_write,
    output logic                        dma_rsp_err,
    output logic [DCCM_FDATA_WIDTH-1:0] dma_rsp_rdata,
    input  logic                        core_dccm_busy,
    input  logic                        lsu_freeze_dc3,
    output logic                        dccm_wren,
    output logic                        dccm_rden,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
    output logic                        dma_prio_req
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, RDATA, RSP} state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic                        req_write;
    logic [DCCM_BITS-1:0]        req_addr;
    logic [DCCM_FDATA_WIDTH-1:0] req_wdata;
    logic                        rsp_err;
    logic [DCCM_FDATA_WIDTH-1:0] rsp_rdata;
    logic [CNT_W-1:0]            starve_cnt;
    logic                        accept;
    logic                        fire;
    logic                        capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        fire          = 1'b0;
        capture       = 1'b0;
        dma_req_ready = 1'b0;
        dma_rsp_valid = 1'b0;
        dccm_wren     = 1'b0;
        dccm_rden     = 1'b0;
        case (state)
            IDLE: begin
                dma_req_ready = 1'b1;
                if (dma_req_valid) begin
                    accept    = 1'b1;
                    state_nxt = (dma_req_addr[1:0] != 2'b00) ? RSP : ISSUE;
                end
            end
            ISSUE: begin
                if (!core_dccm_busy && !lsu_freeze_dc3) begin
                    fire      = 1'b1;
                    dccm_wren = req_write;
                    dccm_rden = !req_write;
                    state_nxt = req_write ? RSP : RDATA;
                end
            end
            RDATA: begin
                // The array holds its output while frozen, so capture can wait.
                if (!lsu_freeze_dc3) begin
                    capture   = 1'b1;
                    state_nxt = RSP;
                end
            end
            RSP: begin
                dma_rsp_valid = 1'b1;
                if (dma_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                req_write <= dma_req_write;
                req_addr  <= dma_req_addr;
                req_wdata <= dma_req_wdata;
                rsp_err   <= (dma_req_addr[1:0] != 2'b00);
                rsp_rdata <= '0;
            end
            if (capture) begin
                rsp_rdata <= dccm_rd_data_lo;
            end
        end
    end

    // Counts blocked ISSUE cycles; anything else (fire or other state) clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == ISSUE && !fire) begin
            if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    assign dma_prio_req    = (state == ISSUE) && (starve_cnt == STARVE_MAX);
    assign dccm_wr_addr    = dccm_wren ? req_addr : '0;
    assign dccm_wr_data    = dccm_wren ? req_wdata : '0;
    assign dccm_rd_addr_lo = dccm_rden ? req_addr : '0;
    assign dccm_rd_addr_hi = dccm_rden ? req_addr : '0;
    assign dma_rsp_write   = dma_rsp_valid & req_write;
    assign dma_rsp_err     = dma_rsp_valid & rsp_err;
    assign dma_rsp_rdata   = dma_rsp_valid ? rsp_rdata : '0;

endmodule

// File: tb/tb_lsu_dccm_dma_req.sv
// Bench for lsu_dccm_dma_req: directed vector table, reset corner sequences,
// then random traffic checked against a transaction-level reference.
module tb_lsu_dccm_dma_req;

    localparam int AW  = 16;
    localparam int DW  = 39;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          dma_req_valid;
    logic          dma_req_ready;
    logic          dma_req_write;
    logic [AW-1:0] dma_req_addr;
    logic [DW-1:0] dma_req_wdata;
    logic          dma_rsp_valid;
    logic          dma_rsp_ready;
    logic          dma_rsp_write;
    logic          dma_rsp_err;
    logic [DW-1:0] dma_rsp_rdata;
    logic          core_dccm_busy;
    logic          lsu_freeze_dc3;
    logic          dccm_wren;
    logic          dccm_rden;
    logic [AW-1:0] dccm_wr_addr;
    logic [AW-1:0] dccm_rd_addr_lo;
    logic [AW-1:0] dccm_rd_addr_hi;
    logic [DW-1:0] dccm_wr_data;
    logic [DW-1:0] dccm_rd_data_lo;
    logic          dma_prio_req;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_dccm_dma_req #(.DCCM_BITS(AW), .DCCM_FDATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_write(dma_req_write), .dma_req_addr(dma_req_addr),
        .dma_req_wdata(dma_req_wdata),
        .dma_rsp_valid(dma_rsp_valid), .dma_rsp_ready(dma_rsp_ready),
        .dma_rsp_write(dma_rsp_write), .dma_rsp_err(dma_rsp_err),
        .dma_rsp_rdata(dma_rsp_rdata),
        .core_dccm_busy(core_dccm_busy), .lsu_freeze_dc3(lsu_freeze_dc3),
        .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
        .dccm_wr_addr(dccm_wr_addr), .dccm_rd_addr_lo(dccm_rd_addr_lo),
        .dccm_rd_addr_hi(dccm_rd_addr_hi), .dccm_wr_data(dccm_wr_data),
        .dccm_rd_data_lo(dccm_rd_data_lo), .dma_prio_req(dma_prio_req)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {7'h5A ^ a[6:0], 16'hC0DE, a};
    endfunction

    // DCCM array: write on wren, read data appears the cycle after rden and holds.
    bit   [DW-1:0] mem_dat [1024];
    bit            mem_wr  [1024];
    logic [DW-1:0] rd_q = '0;

    always @(posedge clk) begin
        if (dccm_wren) begin
            mem_dat[dccm_wr_addr[11:2]] <= dccm_wr_data;
            mem_wr[dccm_wr_addr[11:2]]  <= 1'b1;
        end
        if (dccm_rden) begin
            rd_q <= mem_wr[dccm_rd_addr_lo[11:2]] ? mem_dat[dccm_rd_addr_lo[11:2]]
                                                  : init_val(dccm_rd_addr_lo);
        end
    end
    assign dccm_rd_data_lo = rd_q;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(dma_req_ready), 64'd1);
        chk({tag, "_rsp_flags"}, 64'({dma_rsp_valid, dma_rsp_write, dma_rsp_err}), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(dma_rsp_rdata), 64'd0);
        chk({tag, "_en_prio"}, 64'({dccm_wren, dccm_rden, dma_prio_req}), 64'd0);
        chk({tag, "_addrs"}, 64'({dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi}), 64'd0);
        chk({tag, "_wr_data"}, 64'(dccm_wr_data), 64'd0);
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            busy_n;
        int            frz_n;
        int            exp_lat;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
        int            exp_en;
        int            exp_prio_first;
        int            exp_prio_n;
    } vec_t;

    task automatic apply_vec(input vec_t v, input string tag);
        int   cyc, n_en, p_first, p_n, frz_left, lat;
        logic rd_fired, got;
        @(posedge clk); #1;
        dma_req_valid  = 1'b1;
        dma_req_write  = v.wr;
        dma_req_addr   = v.addr;
        dma_req_wdata  = v.wdata;
        core_dccm_busy = 1'b0;
        lsu_freeze_dc3 = 1'b0;
        dma_rsp_ready  = 1'b0;
        @(negedge clk);
        chk({tag, "_req_ready"}, 64'(dma_req_ready), 64'd1);
        @(posedge clk); #1;
        dma_req_valid = 1'b0;
        cyc = 0; n_en = 0; p_first = 0; p_n = 0; lat = 0;
        frz_left = v.frz_n; rd_fired = 1'b0; got = 1'b0;
        while (!got && cyc < 40) begin
            cyc++;
            core_dccm_busy = (cyc <= v.busy_n);
            lsu_freeze_dc3 = 1'b0;
            if (rd_fired && frz_left > 0) begin
                lsu_freeze_dc3 = 1'b1;
                frz_left--;
            end
            @(negedge clk);
            if (dccm_wren || dccm_rden) n_en++;
            if (dma_prio_req) begin
                p_n++;
                if (p_first == 0) p_first = cyc;
            end
            if (dccm_rden) rd_fired = 1'b1;
            if (dma_rsp_valid) begin
                got = 1'b1;
                lat = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, "_rsp_seen"}, 64'(got), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, "_rsp_write"}, 64'(dma_rsp_write), 64'(v.wr));
        chk({tag, "_rsp_err"}, 64'(dma_rsp_err), 64'(v.exp_err));
        chk({tag, "_rsp_rdata"}, 64'(dma_rsp_rdata), 64'(v.exp_rdata));
        chk({tag, "_enables"}, 64'(n_en), 64'(v.exp_en));
        chk({tag, "_prio_first"}, 64'(p_first), 64'(v.exp_prio_first));
        chk({tag, "_prio_cycles"}, 64'(p_n), 64'(v.exp_prio_n));
        core_dccm_busy = 1'b0;
        lsu_freeze_dc3 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_rsp_hold"}, 64'({dma_rsp_valid, dma_rsp_rdata}), 64'({1'b1, v.exp_rdata}));
        dma_rsp_ready = 1'b1;
        @(posedge clk); #1;
        dma_rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_back_idle"}, 64'({dma_req_ready, dma_rsp_valid, dccm_wren, dccm_rden}), 64'b1000);
    endtask

    vec_t vt [10];

    // Random-phase reference state
    bit   [DW-1:0] ref_dat [1024];
    bit            ref_wr  [1024];

    initial begin
        logic          have_txn, t_wr, t_err, issue_pend, accepted, got;
        logic [AW-1:0] t_addr, a;
        logic [DW-1:0] t_wdata, t_rdata;
        int            n_en, blocked, bp, idx;

        vt[0] = '{wr:1'b1, addr:16'h0010, wdata:39'h12345678,   busy_n:0, frz_n:0, exp_lat:2, exp_err:1'b0, exp_rdata:39'h0,          exp_en:1, exp_prio_first:0, exp_prio_n:0};
        vt[1] = '{wr:1'b0, addr:16'h0010, wdata:39'h0,          busy_n:0, frz_n:0, exp_lat:3, exp_err:1'b0, exp_rdata:39'h12345678,   exp_en:1, exp_prio_first:0, exp_prio_n:0};
        vt[2] = '{wr:1'b0, addr:16'h0010, wdata:39'h0,          busy_n:6, frz_n:0, exp_lat:9, exp_err:1'b0, exp_rdata:39'h12345678,   exp_en:1, exp_prio_first:5, exp_prio_n:3};
        vt[3] = '{wr:1'b0, addr:16'h0010, wdata:39'h0,          busy_n:0, frz_n:3, exp_lat:6, exp_err:1'b0, exp_rdata:39'h12345678,   exp_en:1, exp_prio_first:0, exp_prio_n:0};
        vt[4] = '{wr:1'b1, addr:16'h0013, wdata:39'h55,         busy_n:0, frz_n:0, exp_lat:1, exp_err:1'b1, exp_rdata:39'h0,          exp_en:0, exp_prio_first:0, exp_prio_n:0};
        vt[5] = '{wr:1'b0, addr:16'h0002, wdata:39'h0,          busy_n:0, frz_n:0, exp_lat:1, exp_err:1'b1, exp_rdata:39'h0,          exp_en:0, exp_prio_first:0, exp_prio_n:0};
        vt[6] = '{wr:1'b1, addr:16'h0014, wdata:39'h7FDEADBEEF, busy_n:2, frz_n:0, exp_lat:4, exp_err:1'b0, exp_rdata:39'h0,          exp_en:1, exp_prio_first:0, exp_prio_n:0};
        vt[7] = '{wr:1'b0, addr:16'h0014, wdata:39'h0,          busy_n:1, frz_n:1, exp_lat:5, exp_err:1'b0, exp_rdata:39'h7FDEADBEEF, exp_en:1, exp_prio_first:0, exp_prio_n:0};
        vt[8] = '{wr:1'b0, addr:16'h0010, wdata:39'h0,          busy_n:4, frz_n:0, exp_lat:7, exp_err:1'b0, exp_rdata:39'h12345678,   exp_en:1, exp_prio_first:5, exp_prio_n:1};
        vt[9] = '{wr:1'b1, addr:16'h0018, wdata:39'h1,          busy_n:3, frz_n:0, exp_lat:5, exp_err:1'b0, exp_rdata:39'h0,          exp_en:1, exp_prio_first:0, exp_prio_n:0};

        rst = 1'b1;
        dma_req_valid = 1'b0; dma_req_write = 1'b0; dma_req_addr = '0; dma_req_wdata = '0;
        dma_rsp_ready = 1'b0; core_dccm_busy = 1'b0; lsu_freeze_dc3 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Reset arriving while the read sits in a frozen RDATA
        @(posedge clk); #1;
        dma_req_valid = 1'b1; dma_req_write = 1'b0; dma_req_addr = 16'h0014;
        @(posedge clk); #1;
        dma_req_valid = 1'b0;
        @(negedge clk);
        chk("rst_rdata_rden", 64'(dccm_rden), 64'd1);
        @(posedge clk); #1;
        lsu_freeze_dc3 = 1'b1;
        #2 rst = 1'b1;
        #1 chk_idle_outputs("rst_rdata");
        @(posedge clk); #1;
        rst = 1'b0;
        lsu_freeze_dc3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_rdata_after%0d", k),
                64'({dma_req_ready, dma_rsp_valid, dccm_wren, dccm_rden}), 64'b1000);
            @(posedge clk); #1;
        end

        // Reset while a response is waiting on dma_rsp_ready
        dma_req_valid = 1'b1; dma_req_write = 1'b0; dma_req_addr = 16'h0010;
        @(posedge clk); #1;
        dma_req_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (dma_rsp_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("rst_rsp_reached", 64'(got), 64'd1);
        rst = 1'b1;
        #1 chk_idle_outputs("rst_rsp");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_after", 64'({dma_req_ready, dma_rsp_valid}), 64'b10);

        // Random traffic against a transaction-level reference
        @(posedge clk); #1;
        have_txn = 1'b0; accepted = 1'b0; issue_pend = 1'b0;
        t_wr = 1'b0; t_err = 1'b0; t_addr = '0; t_wdata = '0; t_rdata = '0;
        n_en = 0; blocked = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (accepted) begin
                dma_req_valid = 1'b0;
                accepted = 1'b0;
            end
            if (!dma_req_valid && $urandom_range(0, 2) == 0) begin
                a = AW'(16'h0100 + 4 * $urandom_range(0, 7));
                if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
                dma_req_valid = 1'b1;
                dma_req_write = 1'($urandom_range(0, 1));
                dma_req_addr  = a;
                dma_req_wdata = DW'({$urandom(), $urandom()});
            end
            bp = (c < 1000) ? 20 : (c < 2000) ? 70 : 40;
            core_dccm_busy = ($urandom_range(0, 99) < bp);
            lsu_freeze_dc3 = ($urandom_range(0, 99) < 15);
            dma_rsp_ready  = ($urandom_range(0, 99) < 60);
            @(negedge clk);

            chk("rnd_ready", 64'(dma_req_ready), 64'(!have_txn));
            chk("rnd_one_enable", 64'(dccm_wren && dccm_rden), 64'd0);
            if (!dccm_wren) chk("rnd_wr_addr_zero", 64'(dccm_wr_addr), 64'd0);
            if (!dccm_rden) chk("rnd_rd_addr_zero", 64'({dccm_rd_addr_lo, dccm_rd_addr_hi}), 64'd0);
            if (dccm_wren || dccm_rden) begin
                chk("rnd_en_when_blocked", 64'(core_dccm_busy || lsu_freeze_dc3), 64'd0);
                chk("rnd_en_expected", 64'(issue_pend), 64'd1);
                chk("rnd_en_kind", 64'(dccm_wren), 64'(t_wr));
                if (dccm_wren) begin
                    chk("rnd_wr_addr", 64'(dccm_wr_addr), 64'(t_addr));
                    chk("rnd_wr_data", 64'(dccm_wr_data), 64'(t_wdata));
                end else begin
                    chk("rnd_rd_addr", 64'({dccm_rd_addr_lo, dccm_rd_addr_hi}), 64'({t_addr, t_addr}));
                end
                n_en++;
            end
            chk("rnd_prio", 64'(dma_prio_req), 64'(issue_pend && blocked >= LIM));
            if (issue_pend) begin
                if (dccm_wren || dccm_rden) issue_pend = 1'b0;
                else blocked++;
            end
            if (dma_rsp_valid) begin
                chk("rnd_rsp_has_txn", 64'(have_txn), 64'd1);
                chk("rnd_rsp_fields", 64'({dma_rsp_write, dma_rsp_err}), 64'({t_wr, t_err}));
                chk("rnd_rsp_rdata", 64'(dma_rsp_rdata), 64'(t_rdata));
                if (dma_rsp_ready) begin
                    chk("rnd_enable_count", 64'(n_en), 64'(t_err ? 0 : 1));
                    have_txn = 1'b0;
                end
            end
            if (dma_req_valid && dma_req_ready) begin
                accepted   = 1'b1;
                have_txn   = 1'b1;
                t_wr       = dma_req_write;
                t_addr     = dma_req_addr;
                t_wdata    = dma_req_wdata;
                t_err      = (dma_req_addr[1:0] != 2'b00);
                t_rdata    = '0;
                issue_pend = !t_err;
                n_en       = 0;
                blocked    = 0;
                idx        = int'(dma_req_addr[11:2]);
                if (!t_err) begin
                    if (t_wr) begin
                        ref_dat[idx] = dma_req_wdata;
                        ref_wr[idx]  = 1'b1;
                    end else begin
                        t_rdata = ref_wr[idx] ? ref_dat[idx] : init_val(dma_req_addr);
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
